// File: rtl/l1_pmem_arbiter.sv
// Shares one line-wide physical-memory port between the I-cache and D-cache.
// One line transaction at a time, round-robin on ties, all outputs registered.
module l1_pmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int LINE_W   = 256,
   parameter int OFFSET_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_pmem_read,
   input  logic [ADDR_W-1:0] icache_pmem_address,
   output logic [LINE_W-1:0] icache_pmem_rdata,
   output logic              icache_pmem_resp,
   input  logic              dcache_pmem_read,
   input  logic              dcache_pmem_write,
   input  logic [ADDR_W-1:0] dcache_pmem_address,
   input  logic [LINE_W-1:0] dcache_pmem_wdata,
   output logic [LINE_W-1:0] dcache_pmem_rdata,
   output logic              dcache_pmem_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

   localparam logic [ADDR_W-1:0] OFFSET_MASK = {{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

   state_t            state, state_nx;
   logic              last_d, last_d_nx;
   logic              pending_i, pending_d, grant_i, grant_d;
   logic              mem_read_nx, mem_write_nx;
   logic [ADDR_W-1:0] mem_address_nx;
   logic [LINE_W-1:0] mem_wdata_nx;
   logic [LINE_W-1:0] icache_rdata_nx, dcache_rdata_nx;
   logic              icache_resp_nx, dcache_resp_nx;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return addr & ~OFFSET_MASK;
   endfunction

   always_comb begin
      state_nx        = state;
      last_d_nx       = last_d;
      mem_read_nx     = mem_read;
      mem_write_nx    = mem_write;
      mem_address_nx  = mem_address;
      mem_wdata_nx    = mem_wdata;
      icache_rdata_nx = icache_pmem_rdata;
      dcache_rdata_nx = dcache_pmem_rdata;
      icache_resp_nx  = 1'b0;
      dcache_resp_nx  = 1'b0;
      pending_i       = icache_pmem_read;
      pending_d       = dcache_pmem_read | dcache_pmem_write;
      // On a tie the side that was not served last wins
      grant_i         = pending_i & (~pending_d | last_d);
      grant_d         = pending_d & (~pending_i | ~last_d);

      case (state)
         IDLE: begin
            if (grant_i) begin
               state_nx       = BUSY_I;
               mem_read_nx    = 1'b1;
               mem_address_nx = line_align(icache_pmem_address);
               if (pending_d) last_d_nx = 1'b0;
            end else if (grant_d) begin
               state_nx       = BUSY_D;
               mem_address_nx = line_align(dcache_pmem_address);
               if (dcache_pmem_write) begin
                  mem_write_nx = 1'b1;
                  mem_wdata_nx = dcache_pmem_wdata;
               end else begin
                  mem_read_nx  = 1'b1;
               end
               if (pending_i) last_d_nx = 1'b1;
            end
         end
         BUSY_I: begin
            if (mem_resp) begin
               mem_read_nx     = 1'b0;
               icache_rdata_nx = mem_rdata;
               icache_resp_nx  = 1'b1;
               state_nx        = RELEASE;
            end
         end
         BUSY_D: begin
            if (mem_resp) begin
               mem_read_nx    = 1'b0;
               mem_write_nx   = 1'b0;
               if (!mem_write) dcache_rdata_nx = mem_rdata;
               dcache_resp_nx = 1'b1;
               state_nx       = RELEASE;
            end
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Extra RELEASE cycle lets the served client drop its held request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         last_d            <= 1'b1;
         mem_read          <= 1'b0;
         mem_write         <= 1'b0;
         mem_address       <= '0;
         mem_wdata         <= '0;
         icache_pmem_rdata <= '0;
         dcache_pmem_rdata <= '0;
         icache_pmem_resp  <= 1'b0;
         dcache_pmem_resp  <= 1'b0;
      end else begin
         state             <= state_nx;
         last_d            <= last_d_nx;
         mem_read          <= mem_read_nx;
         mem_write         <= mem_write_nx;
         mem_address       <= mem_address_nx;
         mem_wdata         <= mem_wdata_nx;
         icache_pmem_rdata <= icache_rdata_nx;
         dcache_pmem_rdata <= dcache_rdata_nx;
         icache_pmem_resp  <= icache_resp_nx;
         dcache_pmem_resp  <= dcache_resp_nx;
      end
   end

endmodule
